game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Parametrised game-flow controller for the VGA runner.
- Sequences the intro: countdown, logo slide-out and player slide-in. Then runs play with N-lane stepping, score, lives and game-over.
- Runs on the system clock, with state advancing only on a one-cycle frame_tick strobe (one per VGA frame).
- Outputs drive layer offsets and spawn enables. Collision results come back in from the coin/hazard logic.

Parameters:
- OFS_W, 12, width of all offset outputs (two's complement)
- LANES, 3, lane count; must be odd and ≥3
- LANE_PITCH, 100, horizontal pixels between adjacent lanes
- COUNTDOWN, 5, countdown reload value
- LOGO_END, 640, logo voffset at which the slide stops
- LOGO_STEP, 30, logo voffset increment per frame
- HEAD_START, 180, initial player voffset
- HEAD_END, 50, player voffset threshold
- HEAD_STEP, 20, player voffset decrement per frame
- LIVES, 3, starting lives (≥1)
- SCORE_W, 16, score width
- COIN_VALUE, 1, score added per coin
- OVER_HOLD, 120, frames held in OVER (optional feature only)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle strobe per frame; all state advances only when it is high
- btn_left  in  1  move-left button, synchronised level
- btn_right  in  1  move-right button, synchronised level
- coin_hit  in  1  coin collected, pulse on any clk cycle
- hazard_hit  in  1  obstacle struck, pulse on any clk cycle
- state_o  out  3  0=COUNT, 1=LOGO, 2=HEAD, 3=PLAY, 4=OVER
- logo_voffset  out  OFS_W  logo layer voffset
- head_voffset  out  OFS_W  player layer voffset
- head_hoffset  out  OFS_W  player hoffset, signed
- lane_idx  out  $clog2(LANES)  current lane, 0 = leftmost
- spawn_en  out  1  high only in PLAY
- score  out  SCORE_W  current score
- lives  out  $clog2(LIVES+1)  remaining lives
- game_over  out  1  high only in OVER

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous, active-high, and overrides frame_tick.
- Reset values: state=COUNT, cnt=COUNTDOWN, logo_voffset=0, head_voffset=HEAD_START, lane_idx=(LANES-1)/2, head_hoffset=0, score=0, lives=LIVES. Pending flags, button history, spawn_en and game_over are all 0.
- All outputs are registered. spawn_en and game_over are decoded from the registered state.
- COUNT, on each tick: if cnt>0 then cnt−1, else go to LOGO. Dwell is COUNTDOWN+1 ticks.
- LOGO, on each tick: if logo_voffset<LOGO_END then add LOGO_STEP, else go to HEAD. Defaults: value ends at 660 after 22 adds; the transition happens on the 23rd tick.
- HEAD, on each tick: if head_voffset>HEAD_END then subtract HEAD_STEP, else go to PLAY. Defaults: 180→40 over 7 ticks; PLAY is entered on the 8th tick.
- Buttons: sampled only on ticks; the previous sample is kept in every state.
  - A move needs a rising edge (1 now, 0 at the previous tick), and only in PLAY.
  - Left moves lane_idx−1, clamped at 0. Right moves +1, clamped at LANES−1.
  - Both edges on the same tick: no move.
  - A button held while entering PLAY does not move the player.
- head_hoffset = (lane_idx − (LANES−1)/2)·LANE_PITCH, in signed OFS_W arithmetic. It is registered alongside lane_idx, so both change on the same edge.
- Hit events:
  - coin_hit and hazard_hit set sticky pending flags on any cycle. A hit on the same cycle as a tick is included in that tick.
  - Each tick consumes and clears both flags. Outside PLAY, pending hits are discarded.
  - Multiple pulses between ticks count once.
- PLAY tick with pending coin: score += COIN_VALUE, saturating at 2^SCORE_W−1.
- PLAY tick with pending hazard: lives−1. If the result is 0, go to OVER on the same tick.
- Coin and hazard on the same tick: both apply.
- OVER: spawn_en=0, game_over=1. Lane, offsets and score are frozen and inputs are ignored. Exit is by rst only, unless the optional feature is enabled.
- Illegal state encodings (5–7) go to COUNT with reset values on the next tick.

Optional Feature:
- Macro: GAME_SEQ_ATTRACT_LOOP_EN.
- Defined: OVER counts OVER_HOLD ticks, then performs the reset-value load (including score and lives) and enters COUNT. Restart happens without rst.
- Undefined: OVER is held until rst and no hold counter is synthesised.

Test Plan:
- Defaults: rst, then 1 tick/frame → state_o=0 for 6 ticks, 1 for 23, 2 for 8, then 3; logo_voffset=660, head_voffset=40, spawn_en=1.
- In PLAY (lane 1): right rising edge → lane 2, hoffset=100. Second right edge → still lane 2. Three left edges → lane 0, hoffset=−100. Held button across ticks → one move only. Both pressed → no move.
- coin_hit on a non-tick cycle → score 0→1 at the next tick. Three coin pulses before one tick → score +1. Score preset near max with SCORE_W=4, COIN_VALUE=3 → saturates at 15.
- Three hazard ticks → lives 3→2→1→0, state_o=4 on the third tick, game_over=1, spawn_en=0. Coin and hazard on the same tick → score+1 and lives−1.
- rst asserted mid-LOGO without frame_tick → next cycle shows reset values and state_o=0. coin_hit during COUNT → discarded, score stays 0.
- GAME_SEQ_ATTRACT_LOOP_EN defined, OVER_HOLD=4: four ticks after OVER → state_o=0, lives=3, score=0. Undefined: stays in OVER for 1000 ticks.

Source files
------------

// File: rtl/game_sequencer.sv
// Purpose : game-flow controller for the VGA runner. It runs the countdown, the logo slide-out and the player
//           slide-in, then play with lane stepping, score, lives and game-over. GAME_SEQ_ATTRACT_LOOP_EN enables the OVER hold and automatic restart.
// Latency : every output is registered and updates on the clk edge that samples frame_tick (or rst).
// Backpr. : none; hit pulses are latched in sticky pending flags until the next frame_tick consumes them.
module game_sequencer #(
    parameter int OFS_W      = 12,
    parameter int LANES      = 3,
    parameter int LANE_PITCH = 100,
    parameter int COUNTDOWN  = 5,
    parameter int LOGO_END   = 640,
    parameter int LOGO_STEP  = 30,
    parameter int HEAD_START = 180,
    parameter int HEAD_END   = 50,
    parameter int HEAD_STEP  = 20,
    parameter int LIVES      = 3,
    parameter int SCORE_W    = 16,
    parameter int COIN_VALUE = 1,
    parameter int OVER_HOLD  = 120
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_tick,
    input  logic                         btn_left,
    input  logic                         btn_right,
    input  logic                         coin_hit,
    input  logic                         hazard_hit,
    output logic [2:0]                   state_o,
    output logic [OFS_W-1:0]             logo_voffset,
    output logic [OFS_W-1:0]             head_voffset,
    output logic [OFS_W-1:0]             head_hoffset,
    output logic [$clog2(LANES)-1:0]     lane_idx,
    output logic                         spawn_en,
    output logic [SCORE_W-1:0]           score,
    output logic [$clog2(LIVES+1)-1:0]   lives,
    output logic                         game_over
);

    localparam int LANE_W = $clog2(LANES);
    localparam int LIV_W  = $clog2(LIVES + 1);
    localparam int CNT_W  = (COUNTDOWN > 0) ? $clog2(COUNTDOWN + 1) : 1;

    localparam logic [LANE_W-1:0]  LANE_MID   = LANE_W'((LANES - 1) / 2);
    localparam logic [LANE_W-1:0]  LANE_MAX   = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]   CNT_INIT   = CNT_W'(COUNTDOWN);
    localparam logic [LIV_W-1:0]   LIV_INIT   = LIV_W'(LIVES);
    localparam logic [OFS_W-1:0]   LOGO_END_V = OFS_W'(LOGO_END);
    localparam logic [OFS_W-1:0]   LOGO_STP_V = OFS_W'(LOGO_STEP);
    localparam logic [OFS_W-1:0]   HEAD_INI_V = OFS_W'(HEAD_START);
    localparam logic [OFS_W-1:0]   HEAD_END_V = OFS_W'(HEAD_END);
    localparam logic [OFS_W-1:0]   HEAD_STP_V = OFS_W'(HEAD_STEP);
    localparam logic [OFS_W-1:0]   PITCH_V    = OFS_W'(LANE_PITCH);
    localparam logic [SCORE_W:0]   COIN_V     = (SCORE_W + 1)'(COIN_VALUE);
    localparam logic [SCORE_W:0]   SCORE_MAX  = {1'b0, {SCORE_W{1'b1}}};

    typedef enum logic [2:0] {
        ST_COUNT = 3'd0,
        ST_LOGO  = 3'd1,
        ST_HEAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [OFS_W-1:0]    r_logo;
    logic [OFS_W-1:0]    r_head;
    logic [OFS_W-1:0]    r_hoff;
    logic [LANE_W-1:0]   r_lane;
    logic [SCORE_W-1:0]  r_score;
    logic [LIV_W-1:0]    r_lives;
    logic                r_spawn;
    logic                r_over;
    logic                r_coin_pend;
    logic                r_haz_pend;
    logic                r_bl_prev;
    logic                r_br_prev;

    state_t              w_nxt_state;
    logic [CNT_W-1:0]    w_nxt_cnt;
    logic [OFS_W-1:0]    w_nxt_logo;
    logic [OFS_W-1:0]    w_nxt_head;
    logic [OFS_W-1:0]    w_nxt_hoff;
    logic [LANE_W-1:0]   w_nxt_lane;
    logic [SCORE_W-1:0]  w_nxt_score;
    logic [LIV_W-1:0]    w_nxt_lives;
    logic                w_nxt_spawn;
    logic                w_nxt_over;
    logic                w_nxt_coin_pend;
    logic                w_nxt_haz_pend;
    logic                w_nxt_bl_prev;
    logic                w_nxt_br_prev;
    logic                w_load_init;

    // Hits arriving on the tick cycle itself belong to that tick.
    logic                w_coin_evt;
    logic                w_haz_evt;
    logic                w_rise_l;
    logic                w_rise_r;
    logic [SCORE_W:0]    w_score_sum;
    logic [OFS_W-1:0]    w_lane_ext;

    assign w_coin_evt  = r_coin_pend | coin_hit;
    assign w_haz_evt   = r_haz_pend | hazard_hit;
    assign w_rise_l    = btn_left & ~r_bl_prev;
    assign w_rise_r    = btn_right & ~r_br_prev;
    assign w_score_sum = {1'b0, r_score} + COIN_V;
    assign w_lane_ext  = OFS_W'(w_nxt_lane);

`ifdef GAME_SEQ_ATTRACT_LOOP_EN
    localparam int HOLD_W = (OVER_HOLD > 1) ? $clog2(OVER_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OVER_HOLD - 1);
    logic [HOLD_W-1:0]   r_hold;
    logic [HOLD_W-1:0]   w_nxt_hold;
`else
    // OVER is terminal in this build, so the hold length has no hardware behind it.
    logic                w_unused_hold;
    assign w_unused_hold = (OVER_HOLD != 0);
`endif

    // Next-state and next-output decode; everything holds unless frame_tick is high.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cnt       = r_cnt;
        w_nxt_logo      = r_logo;
        w_nxt_head      = r_head;
        w_nxt_lane      = r_lane;
        w_nxt_score     = r_score;
        w_nxt_lives     = r_lives;
        w_nxt_coin_pend = w_coin_evt;
        w_nxt_haz_pend  = w_haz_evt;
        w_nxt_bl_prev   = r_bl_prev;
        w_nxt_br_prev   = r_br_prev;
        w_load_init     = 1'b0;
        w_nxt_hoff      = r_hoff;
        w_nxt_spawn     = r_spawn;
        w_nxt_over      = r_over;
`ifdef GAME_SEQ_ATTRACT_LOOP_EN
        w_nxt_hold      = (r_state == ST_OVER) ? r_hold : '0;
`endif
        if (frame_tick) begin
            // Each tick consumes the pending hits; outside PLAY they are simply dropped.
            w_nxt_coin_pend = 1'b0;
            w_nxt_haz_pend  = 1'b0;
            w_nxt_bl_prev   = btn_left;
            w_nxt_br_prev   = btn_right;
            case (r_state)
                ST_COUNT: begin
                    if (r_cnt != '0) begin
                        w_nxt_cnt = r_cnt - CNT_W'(1);
                    end else begin
                        w_nxt_state = ST_LOGO;
                    end
                end
                ST_LOGO: begin
                    if ($signed(r_logo) < $signed(LOGO_END_V)) begin
                        w_nxt_logo = r_logo + LOGO_STP_V;
                    end else begin
                        w_nxt_state = ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if ($signed(r_head) > $signed(HEAD_END_V)) begin
                        w_nxt_head = r_head - HEAD_STP_V;
                    end else begin
                        w_nxt_state = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // Simultaneous edges cancel; moves clamp at the outer lanes.
                    if (w_rise_l && !w_rise_r) begin
                        if (r_lane != '0) begin
                            w_nxt_lane = r_lane - LANE_W'(1);
                        end
                    end else if (w_rise_r && !w_rise_l) begin
                        if (r_lane != LANE_MAX) begin
                            w_nxt_lane = r_lane + LANE_W'(1);
                        end
                    end
                    if (w_coin_evt) begin
                        w_nxt_score = (w_score_sum > SCORE_MAX) ? {SCORE_W{1'b1}}
                                                                : w_score_sum[SCORE_W-1:0];
                    end
                    if (w_haz_evt && (r_lives != '0)) begin
                        w_nxt_lives = r_lives - LIV_W'(1);
                        if (r_lives == LIV_W'(1)) begin
                            w_nxt_state = ST_OVER;
                        end
                    end
                end
                ST_OVER: begin
`ifdef GAME_SEQ_ATTRACT_LOOP_EN
                    if (r_hold == HOLD_LAST) begin
                        w_load_init = 1'b1;
                    end else begin
                        w_nxt_hold = r_hold + HOLD_W'(1);
                    end
`endif
                end
                default: begin
                    // Corrupted encoding: recover through a full reload.
                    w_load_init = 1'b1;
                end
            endcase
        end
        if (w_load_init) begin
            w_nxt_state     = ST_COUNT;
            w_nxt_cnt       = CNT_INIT;
            w_nxt_logo      = '0;
            w_nxt_head      = HEAD_INI_V;
            w_nxt_lane      = LANE_MID;
            w_nxt_score     = '0;
            w_nxt_lives     = LIV_INIT;
            w_nxt_coin_pend = 1'b0;
            w_nxt_haz_pend  = 1'b0;
            w_nxt_bl_prev   = 1'b0;
            w_nxt_br_prev   = 1'b0;
        end
        // hoffset is derived from the next lane so that both registers move on the same edge.
        w_nxt_hoff  = (w_lane_ext - OFS_W'(LANE_MID)) * PITCH_V;
        w_nxt_spawn = (w_nxt_state == ST_PLAY);
        w_nxt_over  = (w_nxt_state == ST_OVER);
    end

    // State and output registers with synchronous reset taking priority over frame_tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_COUNT;
            r_cnt       <= CNT_INIT;
            r_logo      <= '0;
            r_head      <= HEAD_INI_V;
            r_hoff      <= '0;
            r_lane      <= LANE_MID;
            r_score     <= '0;
            r_lives     <= LIV_INIT;
            r_spawn     <= 1'b0;
            r_over      <= 1'b0;
            r_coin_pend <= 1'b0;
            r_haz_pend  <= 1'b0;
            r_bl_prev   <= 1'b0;
            r_br_prev   <= 1'b0;
`ifdef GAME_SEQ_ATTRACT_LOOP_EN
            r_hold      <= '0;
`endif
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_logo      <= w_nxt_logo;
            r_head      <= w_nxt_head;
            r_hoff      <= w_nxt_hoff;
            r_lane      <= w_nxt_lane;
            r_score     <= w_nxt_score;
            r_lives     <= w_nxt_lives;
            r_spawn     <= w_nxt_spawn;
            r_over      <= w_nxt_over;
            r_coin_pend <= w_nxt_coin_pend;
            r_haz_pend  <= w_nxt_haz_pend;
            r_bl_prev   <= w_nxt_bl_prev;
            r_br_prev   <= w_nxt_br_prev;
`ifdef GAME_SEQ_ATTRACT_LOOP_EN
            r_hold      <= w_nxt_hold;
`endif
        end
    end

    assign state_o      = r_state;
    assign logo_voffset = r_logo;
    assign head_voffset = r_head;
    assign head_hoffset = r_hoff;
    assign lane_idx     = r_lane;
    assign spawn_en     = r_spawn;
    assign score        = r_score;
    assign lives        = r_lives;
    assign game_over    = r_over;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus queues the expected outputs for every tick/reset edge,
// monitors pop and compare after each such edge. A second small instance covers score saturation.
module tb_game_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0, frame_tick = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        coin_hit = 1'b0, hazard_hit = 1'b0;
    logic [2:0]  state_o;
    logic [11:0] logo_voffset, head_voffset, head_hoffset;
    logic [1:0]  lane_idx;
    logic        spawn_en;
    logic [15:0] score;
    logic [1:0]  lives;
    logic        game_over;

    game_sequencer #(.OVER_HOLD(4)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right),
        .coin_hit(coin_hit), .hazard_hit(hazard_hit),
        .state_o(state_o), .logo_voffset(logo_voffset), .head_voffset(head_voffset),
        .head_hoffset(head_hoffset), .lane_idx(lane_idx), .spawn_en(spawn_en),
        .score(score), .lives(lives), .game_over(game_over)
    );

    // Small instance: reaches PLAY in three ticks, 4-bit score, 3 points per coin.
    logic        rst2 = 1'b0, tick2 = 1'b0, coin2 = 1'b0;
    logic [2:0]  s2_state;
    logic [11:0] s2_logo, s2_head, s2_hoff;
    logic [1:0]  s2_lane;
    logic        s2_spawn;
    logic [3:0]  s2_score;
    logic [1:0]  s2_lives;
    logic        s2_over;

    game_sequencer #(
        .SCORE_W(4), .COIN_VALUE(3), .COUNTDOWN(0), .LOGO_END(0),
        .HEAD_START(50), .HEAD_END(50), .OVER_HOLD(4)
    ) dut2 (
        .clk(clk), .rst(rst2), .frame_tick(tick2),
        .btn_left(1'b0), .btn_right(1'b0),
        .coin_hit(coin2), .hazard_hit(1'b0),
        .state_o(s2_state), .logo_voffset(s2_logo), .head_voffset(s2_head),
        .head_hoffset(s2_hoff), .lane_idx(s2_lane), .spawn_en(s2_spawn),
        .score(s2_score), .lives(s2_lives), .game_over(s2_over)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [11:0] logo;
        logic [11:0] head;
        logic [11:0] hoff;
        logic [1:0]  lane;
        logic        spawn;
        logic [15:0] score;
        logic [1:0]  lives;
        logic        over;
    } exp_t;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] score;
        logic [1:0] lives;
        logic       spawn;
    } exp2_t;

    exp_t  q1[$];
    exp2_t q2[$];
    int    checks = 0;
    int    failures = 0;
    int    ev1 = 0;
    int    ev2 = 0;

    logic [2:0]  e_state;
    logic [11:0] e_logo, e_head, e_hoff;
    logic [1:0]  e_lane;
    logic        e_spawn;
    logic [15:0] e_score;
    logic [1:0]  e_lives;
    logic        e_over;

    task automatic set_reset_exp();
        e_state = 3'd0; e_logo = 12'd0; e_head = 12'd180; e_hoff = 12'd0;
        e_lane = 2'd1; e_spawn = 1'b0; e_score = 16'd0; e_lives = 2'd3; e_over = 1'b0;
    endtask

    task automatic push_exp();
        exp_t e;
        e = '{e_state, e_logo, e_head, e_hoff, e_lane, e_spawn, e_score, e_lives, e_over};
        q1.push_back(e);
    endtask

    // Main monitor: every reset or tick edge must match the oldest queued expectation.
    always @(posedge clk) begin
        if (frame_tick || rst) begin
            exp_t a;
            exp_t e;
            #1;
            ev1++;
            checks++;
            a = '{state_o, logo_voffset, head_voffset, head_hoffset, lane_idx, spawn_en, score, lives, game_over};
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL main_sb ev%0d: DUT output with no expectation queued", ev1);
            end else begin
                e = q1.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL main_sb ev%0d: got st=%0d logo=%0d head=%0d hoff=%0d lane=%0d spawn=%b score=%0d lives=%0d over=%b; want st=%0d logo=%0d head=%0d hoff=%0d lane=%0d spawn=%b score=%0d lives=%0d over=%b",
                             ev1, a.st, a.logo, a.head, $signed(a.hoff), a.lane, a.spawn, a.score, a.lives, a.over,
                             e.st, e.logo, e.head, $signed(e.hoff), e.lane, e.spawn, e.score, e.lives, e.over);
                end
            end
        end
    end

    // Saturation monitor for the small instance.
    always @(posedge clk) begin
        if (tick2 || rst2) begin
            exp2_t a;
            exp2_t e;
            #1;
            ev2++;
            checks++;
            a = '{s2_state, s2_score, s2_lives, s2_spawn};
            if (q2.size() == 0) begin
                failures++;
                $display("FAIL sat_sb ev%0d: DUT output with no expectation queued", ev2);
            end else begin
                e = q2.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL sat_sb ev%0d: got st=%0d score=%0d lives=%0d spawn=%b; want st=%0d score=%0d lives=%0d spawn=%b",
                             ev2, a.st, a.score, a.lives, a.spawn, e.st, e.score, e.lives, e.spawn);
                end
            end
        end
    end

    task automatic do_reset(input int n);
        set_reset_exp();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            push_exp();
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One frame tick; e_* must already hold the values expected after it.
    task automatic tick(input logic bl, input logic br, input logic c, input logic h);
        @(negedge clk);
        btn_left = bl; btn_right = br; coin_hit = c; hazard_hit = h;
        frame_tick = 1'b1;
        push_exp();
        @(negedge clk);
        frame_tick = 1'b0; coin_hit = 1'b0; hazard_hit = 1'b0;
    endtask

    // Hit pulse on a cycle without a tick.
    task automatic pulse(input logic c, input logic h);
        @(negedge clk);
        coin_hit = c; hazard_hit = h;
        @(negedge clk);
        coin_hit = 1'b0; hazard_hit = 1'b0;
    endtask

    // Six ticks in COUNT; the sixth leaves for LOGO.
    task automatic run_count(input logic br);
        for (int i = 1; i <= 6; i++) begin
            e_state = (i == 6) ? 3'd1 : 3'd0;
            tick(1'b0, br, 1'b0, 1'b0);
        end
    endtask

    // LOGO: 22 adds of 30 reach 660, the 23rd tick moves to HEAD.
    task automatic run_logo(input int n, input logic br);
        for (int k = 1; k <= n; k++) begin
            if (k <= 22) begin
                e_logo = 12'(30 * k);
            end else begin
                e_state = 3'd2;
            end
            tick(1'b0, br, 1'b0, 1'b0);
        end
    endtask

    // HEAD: 180 down to 40 in 7 ticks, the 8th enters PLAY.
    task automatic run_head(input logic br);
        for (int k = 1; k <= 8; k++) begin
            if (k <= 7) begin
                e_head = 12'(180 - 20 * k);
            end else begin
                e_state = 3'd3;
                e_spawn = 1'b1;
            end
            tick(1'b0, br, 1'b0, 1'b0);
        end
    endtask

    task automatic tick2_t(input logic c, input exp2_t e);
        @(negedge clk);
        coin2 = c;
        tick2 = 1'b1;
        q2.push_back(e);
        @(negedge clk);
        tick2 = 1'b0;
        coin2 = 1'b0;
    endtask

    initial begin
        logic [3:0] sat_tab [6];
        sat_tab = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd15};

        do_reset(2);
        run_count(1'b0);
        run_logo(23, 1'b0);
        run_head(1'b0);

        // Lane stepping from the centre lane.
        e_lane = 2'd2; e_hoff = 12'd100;      tick(1'b0, 1'b1, 1'b0, 1'b0);
                                              tick(1'b0, 1'b0, 1'b0, 1'b0);
                                              tick(1'b0, 1'b1, 1'b0, 1'b0);
                                              tick(1'b0, 1'b0, 1'b0, 1'b0);
        e_lane = 2'd1; e_hoff = 12'd0;        tick(1'b1, 1'b0, 1'b0, 1'b0);
                                              tick(1'b0, 1'b0, 1'b0, 1'b0);
        e_lane = 2'd0; e_hoff = -12'd100;     tick(1'b1, 1'b0, 1'b0, 1'b0);
                                              tick(1'b0, 1'b0, 1'b0, 1'b0);
                                              tick(1'b1, 1'b0, 1'b0, 1'b0);
                                              tick(1'b0, 1'b0, 1'b0, 1'b0);
        e_lane = 2'd1; e_hoff = 12'd0;        tick(1'b0, 1'b1, 1'b0, 1'b0);
                                              tick(1'b0, 1'b1, 1'b0, 1'b0);
                                              tick(1'b0, 1'b1, 1'b0, 1'b0);
                                              tick(1'b0, 1'b0, 1'b0, 1'b0);
                                              tick(1'b1, 1'b1, 1'b0, 1'b0);
                                              tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Coins: off-tick pulse, triple pulse, pulse on the tick itself.
        pulse(1'b1, 1'b0);
        e_score = 16'd1;                      tick(1'b0, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0); pulse(1'b1, 1'b0); pulse(1'b1, 1'b0);
        e_score = 16'd2;                      tick(1'b0, 1'b0, 1'b0, 1'b0);
        e_score = 16'd3;                      tick(1'b0, 1'b0, 1'b1, 1'b0);

        // Hazards: coin+hazard together, then down to zero lives.
        e_score = 16'd4; e_lives = 2'd2;      tick(1'b0, 1'b0, 1'b1, 1'b1);
        e_lives = 2'd1;                       tick(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        e_lives = 2'd0; e_state = 3'd4; e_spawn = 1'b0; e_over = 1'b1;
                                              tick(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef GAME_SEQ_ATTRACT_LOOP_EN
        // Frozen for three ticks despite inputs, restart on the fourth.
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        set_reset_exp();
        tick(1'b0, 1'b0, 1'b0, 1'b0);
`else
        for (int i = 0; i < 1000; i++) begin
            tick(1'(i % 2), 1'((i / 2) % 2), (i % 3) == 0, (i % 5) == 0);
        end
`endif

        // Coin during COUNT is discarded; reset mid-LOGO without a tick.
        btn_left = 1'b0; btn_right = 1'b0;
        do_reset(1);
        pulse(1'b1, 1'b0);
        run_count(1'b0);
        run_logo(3, 1'b0);
        do_reset(1);

        // Right button held through the whole intro does not move on PLAY entry.
        run_count(1'b1);
        run_logo(23, 1'b1);
        run_head(1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        e_lane = 2'd2; e_hoff = 12'd100;
        tick(1'b0, 1'b1, 1'b0, 1'b0);

        // Saturation on the small instance.
        @(negedge clk);
        rst2 = 1'b1;
        q2.push_back('{3'd0, 4'd0, 2'd3, 1'b0});
        @(negedge clk);
        rst2 = 1'b0;
        tick2_t(1'b0, '{3'd1, 4'd0, 2'd3, 1'b0});
        tick2_t(1'b0, '{3'd2, 4'd0, 2'd3, 1'b0});
        tick2_t(1'b0, '{3'd3, 4'd0, 2'd3, 1'b1});
        for (int k = 0; k < 6; k++) begin
            tick2_t(1'b1, '{3'd3, sat_tab[k], 2'd3, 1'b1});
        end

        // Every queued expectation must have been consumed.
        repeat (4) @(negedge clk);
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d main and %0d sat expectations never matched by DUT events, want 0",
                     q1.size(), q2.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
